// File: rtl/note_sequencer_pkg.sv
// Shared definitions for the tune sequencer: song ROM entry layout, opcodes
// and FSM state encoding.
package note_sequencer_pkg;

   localparam int unsigned NOTE_W   = 6;
   localparam int unsigned DUR_W    = 6;
   localparam int unsigned OP_W     = 2;
   localparam int unsigned ROM_W    = 16;

   localparam int unsigned NOTE_LSB = 0;
   localparam int unsigned DUR_LSB  = 8;
   localparam int unsigned OP_LSB   = 14;

   localparam logic [NOTE_W-1:0] NOTE_SILENCE = NOTE_W'(0);

   typedef enum logic [OP_W-1:0] {
      OP_NOTE = 2'b00,
      OP_REST = 2'b01,
      OP_LOOP = 2'b10,
      OP_END  = 2'b11
   } op_e;

   // Captured song entry; reserved ROM bits are not kept.
   typedef struct packed {
      op_e               op;
      logic [DUR_W-1:0]  dur;
      logic [NOTE_W-1:0] note;
   } rom_entry_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_DECODE,
      S_PLAY
   } state_e;

endpackage

// File: rtl/note_sequencer_tempo_prescaler.sv
// Tempo prescaler: counts 0..TICK_DIV-1 while enabled and flags the last count
// as a tempo tick.
module tempo_prescaler #(
   parameter int unsigned TICK_DIV = 1562500
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic clear,
   output logic tick_c
);

   localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] count_q;

   assign tick_c = enable && (count_q == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (enable) begin
         count_q <= tick_c ? '0 : count_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/note_sequencer.sv
// Tempo-driven tune sequencer: walks the song ROM and presents a held note code
// plus articulation gate to the tone generator.
module note_sequencer
   import note_sequencer_pkg::*;
#(
   parameter int unsigned TICK_DIV  = 1562500,
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned GAP_TICKS = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [ROM_W-1:0]  rom_data,
   output logic [NOTE_W-1:0] fullnote,
   output logic              gate,
   output logic              busy,
   output logic              step
);

   localparam logic [DUR_W-1:0] GAP = DUR_W'(GAP_TICKS);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_d;
   logic [NOTE_W-1:0] note_d;
   logic              gate_d, busy_d, step_d;
   logic [DUR_W-1:0]  remaining_q, remaining_d, rem_dec_c;
   rom_entry_t        entry_q, entry_d;
   logic              tick_c, pre_clear_c;
   logic              unused_rsvd_c;

   assign unused_rsvd_c = ^rom_data[DUR_LSB-1:NOTE_LSB+NOTE_W];
   assign rem_dec_c     = remaining_q - DUR_W'(1);

   tempo_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
      .clk    (clk),
      .rst    (rst),
      .enable (busy),
      .clear  (pre_clear_c),
      .tick_c (tick_c)
   );

   // Next-state and next-output logic; outputs hold unless an event changes them.
   always_comb begin
      state_d     = state_q;
      addr_d      = rom_addr;
      note_d      = fullnote;
      gate_d      = gate;
      step_d      = 1'b0;
      remaining_d = remaining_q;
      entry_d     = entry_q;
      pre_clear_c = 1'b0;

      if (stop) begin
         state_d     = S_IDLE;
         addr_d      = '0;
         note_d      = NOTE_SILENCE;
         gate_d      = 1'b0;
         remaining_d = '0;
         pre_clear_c = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d     = S_FETCH;
                  addr_d      = '0;
                  pre_clear_c = 1'b1;
               end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
               entry_d.op   = op_e'(rom_data[OP_LSB +: OP_W]);
               entry_d.dur  = rom_data[DUR_LSB +: DUR_W];
               entry_d.note = rom_data[NOTE_LSB +: NOTE_W];
               state_d      = S_DECODE;
            end
            S_DECODE: begin
               case (entry_q.op)
                  OP_NOTE, OP_REST: begin
                     if (entry_q.dur == '0) begin
                        addr_d  = rom_addr + ADDR_W'(1);
                        state_d = S_FETCH;
                     end else begin
                        remaining_d = entry_q.dur;
                        note_d      = (entry_q.op == OP_NOTE) ? entry_q.note : NOTE_SILENCE;
                        gate_d      = (entry_q.op == OP_NOTE);
                        step_d      = 1'b1;
                        state_d     = S_PLAY;
                     end
                  end
                  OP_LOOP: begin
                     addr_d = '0;
                     // A loop marker at address 0 would refetch itself forever.
                     if (rom_addr == '0) begin
                        state_d = S_IDLE;
                        note_d  = NOTE_SILENCE;
                        gate_d  = 1'b0;
                     end else begin
                        state_d = S_FETCH;
                     end
                  end
                  default: begin
                     state_d = S_IDLE;
                     addr_d  = '0;
                     note_d  = NOTE_SILENCE;
                     gate_d  = 1'b0;
                  end
               endcase
            end
            S_PLAY: begin
               if (tick_c) begin
                  remaining_d = rem_dec_c;
                  if (rem_dec_c == GAP && entry_q.dur > GAP) begin
                     gate_d = 1'b0;
                  end
                  if (rem_dec_c == '0) begin
                     addr_d  = rom_addr + ADDR_W'(1);
                     state_d = S_FETCH;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         rom_addr    <= '0;
         fullnote    <= NOTE_SILENCE;
         gate        <= 1'b0;
         busy        <= 1'b0;
         step        <= 1'b0;
         remaining_q <= '0;
         entry_q     <= '0;
      end else begin
         state_q     <= state_d;
         rom_addr    <= addr_d;
         fullnote    <= note_d;
         gate        <= gate_d;
         busy        <= busy_d;
         step        <= step_d;
         remaining_q <= remaining_d;
         entry_q     <= entry_d;
      end
   end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: a song-walking timeline model predicts every output
// cycle by cycle; a few literal expectations pin the model.
module tb_note_sequencer;

   localparam int TD   = 4;
   localparam int GAP  = 1;
   localparam int MAXC = 512;

   logic        clk, rst, start, stop, start2, stop2;
   logic [7:0]  rom_addr;
   logic [15:0] rom_data, rom_data2;
   logic [5:0]  fullnote, fullnote2;
   logic        gate, busy, step, gate2, busy2, step2;
   logic [1:0]  rom_addr2;

   logic [15:0] rom  [256];
   logic [15:0] rom2 [4];

   int e_note [MAXC];
   int e_addr [MAXC];
   bit e_gate [MAXC];
   bit e_busy [MAXC];
   bit e_step [MAXC];
   bit e_achk [MAXC];
   int a_note [MAXC];
   int a_addr [MAXC];
   int a_gate [MAXC];
   int a_busy [MAXC];
   int a_step [MAXC];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   bit chk_en  = 0;
   bit sel2    = 0;

   note_sequencer #(.TICK_DIV(TD), .ADDR_W(8), .GAP_TICKS(GAP)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .rom_addr(rom_addr),
      .rom_data(rom_data), .fullnote(fullnote), .gate(gate), .busy(busy), .step(step)
   );

   note_sequencer #(.TICK_DIV(TD), .ADDR_W(2), .GAP_TICKS(GAP)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .stop(stop2), .rom_addr(rom_addr2),
      .rom_data(rom_data2), .fullnote(fullnote2), .gate(gate2), .busy(busy2), .step(step2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External synchronous song ROMs
   always @(posedge clk) rom_data  <= rom[rom_addr];
   always @(posedge clk) rom_data2 <= rom2[rom_addr2];

   function automatic void chk(input string name, input int c, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0d, expected %0d", name, c, act, exp);
      end
   endfunction

   function automatic logic [15:0] ent(input int op, input int dur, input int nt);
      logic [15:0] v;
      v        = '0;
      v[15:14] = 2'(op);
      v[13:8]  = 6'(dur);
      v[5:0]   = 6'(nt);
      return v;
   endfunction

   function automatic void fill(input int from, input int to, input int nt, input bit g,
                                input bit b, input int addr, input bit achk);
      for (int c = from; c < to && c < MAXC; c++) begin
         e_note[c] = nt; e_gate[c] = g; e_busy[c] = b; e_step[c] = 1'b0;
         e_addr[c] = addr; e_achk[c] = achk;
      end
   endfunction

   // Timeline model; cycle 0 is the first cycle after start is sampled and the
   // tempo phase is (cycle mod TD), ticking when it reaches TD-1.
   task automatic build_model(input int n, input int mask, input bit use2, input int stop_at);
      int now, addr, nt, f, p, t1, tend, goff, op, dur, note;
      bit g, done;
      logic [15:0] e;
      now = 0; addr = 0; note = 0; g = 1'b0; done = 1'b0;
      fill(0, MAXC, 0, 1'b0, 1'b0, 0, 1'b0);
      while (!done && now < n) begin
         e    = use2 ? rom2[addr[1:0]] : rom[addr[7:0]];
         op   = int'(e[15:14]);
         dur  = int'(e[13:8]);
         nt   = int'(e[5:0]);
         f    = now;
         fill(f, f + 3, note, g, 1'b1, addr, 1'b1);
         if (op <= 1 && dur > 0) begin
            p    = f + 3;
            note = (op == 0) ? nt : 0;
            t1   = p + (TD - 1 - p % TD);
            tend = t1 + TD * (dur - 1);
            goff = (op == 0 && dur > GAP) ? t1 + TD * (dur - GAP - 1) + 1 : tend + 1;
            for (int c = p; c <= tend && c < MAXC; c++) begin
               e_note[c] = note; e_gate[c] = (op == 0) && (c < goff); e_busy[c] = 1'b1;
               e_step[c] = (c == p); e_addr[c] = addr; e_achk[c] = 1'b1;
            end
            g    = (op == 0) && (goff > tend);
            now  = tend + 1;
            addr = (addr + 1) & mask;
         end else if (op <= 1) begin
            now  = f + 3;
            addr = (addr + 1) & mask;
         end else if (op == 2 && addr != 0) begin
            now  = f + 3;
            addr = 0;
         end else begin
            fill(f + 3, MAXC, 0, 1'b0, 1'b0, 0, 1'b0);
            done = 1'b1;
         end
      end
      if (stop_at >= 0) fill(stop_at + 1, MAXC, 0, 1'b0, 1'b0, 0, 1'b1);
   endtask

   // Compare DUT outputs against the model on every checked cycle
   always @(negedge clk) begin
      if (chk_en && cyc < MAXC) begin
         a_note[cyc] = sel2 ? int'(fullnote2) : int'(fullnote);
         a_gate[cyc] = sel2 ? int'(gate2) : int'(gate);
         a_busy[cyc] = sel2 ? int'(busy2) : int'(busy);
         a_step[cyc] = sel2 ? int'(step2) : int'(step);
         a_addr[cyc] = sel2 ? int'(rom_addr2) : int'(rom_addr);
         chk("fullnote", cyc, a_note[cyc], e_note[cyc]);
         chk("gate", cyc, a_gate[cyc], int'(e_gate[cyc]));
         chk("busy", cyc, a_busy[cyc], int'(e_busy[cyc]));
         chk("step", cyc, a_step[cyc], int'(e_step[cyc]));
         if (e_achk[cyc]) chk("rom_addr", cyc, a_addr[cyc], e_addr[cyc]);
         cyc = cyc + 1;
      end
   end

   task automatic run(input int n, input bit use2, input int stop_at);
      build_model(n, use2 ? 3 : 255, use2, stop_at);
      @(posedge clk); #1;
      if (use2) start2 = 1'b1; else start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; start2 = 1'b0;
      sel2 = use2; cyc = 0; chk_en = 1'b1;
      if (stop_at >= 0) begin
         repeat (stop_at) @(posedge clk);
         #1; stop = 1'b1; start = 1'b1;
         @(posedge clk); #1;
         stop = 1'b0; start = 1'b0;
      end
      wait (cyc >= n);
      chk_en = 1'b0;
   endtask

   task automatic pulse_stop(input bit use2);
      @(posedge clk); #1;
      if (use2) stop2 = 1'b1; else stop = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0; stop2 = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = ent(3, 0, 0);
   endtask

   function automatic int step_count(input int n);
      int s;
      s = 0;
      for (int c = 0; c < n; c++) s += a_step[c];
      return s;
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; start2 = 1'b0; stop2 = 1'b0;
      clear_rom();
      for (int i = 0; i < 4; i++) rom2[i] = ent(3, 0, 0);
      #2;
      chk("reset_fullnote", 0, int'(fullnote), 0);
      chk("reset_gate", 0, int'(gate), 0);
      chk("reset_busy", 0, int'(busy), 0);
      chk("reset_step", 0, int'(step), 0);
      chk("reset_rom_addr", 0, int'(rom_addr), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Single note with articulation gap, then END
      clear_rom();
      rom[0] = ent(0, 3, 20);
      run(30, 1'b0, -1);
      chk("t1_step_c3", 3, a_step[3], 1);
      chk("t1_note_c3", 3, a_note[3], 20);
      chk("t1_gate_c7", 7, a_gate[7], 1);
      chk("t1_gate_c8", 8, a_gate[8], 0);
      chk("t1_busy_c15", 15, a_busy[15], 0);
      chk("t1_steps", 29, step_count(30), 1);

      // Note, rest, note, END
      clear_rom();
      rom[0] = ent(0, 1, 5); rom[1] = ent(1, 2, 0); rom[2] = ent(0, 2, 7);
      run(30, 1'b0, -1);
      chk("t2_note_c3", 3, a_note[3], 5);
      chk("t2_gate_c6", 6, a_gate[6], 1);
      chk("t2_note_c7", 7, a_note[7], 0);
      chk("t2_note_c15", 15, a_note[15], 7);
      chk("t2_gate_c16", 16, a_gate[16], 0);
      chk("t2_busy_c23", 23, a_busy[23], 0);
      chk("t2_steps", 29, step_count(30), 3);

      // Looping song, busy for 50+ ticks
      clear_rom();
      rom[0] = ent(0, 2, 9); rom[1] = ent(2, 0, 0);
      run(210, 1'b0, -1);
      chk("t3_addr_c8", 8, a_addr[8], 1);
      chk("t3_addr_c11", 11, a_addr[11], 0);
      chk("t3_busy_c209", 209, a_busy[209], 1);
      pulse_stop(1'b0);

      // LOOP at address 0 terminates
      clear_rom();
      rom[0] = ent(2, 0, 0);
      run(10, 1'b0, -1);
      chk("t3b_busy_c3", 3, a_busy[3], 0);

      // Zero-duration entry is skipped
      clear_rom();
      rom[0] = ent(0, 2, 3); rom[1] = ent(0, 0, 11); rom[2] = ent(0, 2, 4);
      run(30, 1'b0, -1);
      chk("t4_note_c13", 13, a_note[13], 3);
      chk("t4_note_c14", 14, a_note[14], 4);
      chk("t4_steps", 29, step_count(30), 2);

      // stop together with start mid-PLAY, then a fresh replay
      clear_rom();
      rom[0] = ent(0, 10, 20);
      run(20, 1'b0, 6);
      chk("t5_busy_c7", 7, a_busy[7], 0);
      chk("t5_note_c7", 7, a_note[7], 0);
      run(50, 1'b0, -1);
      chk("t5_replay_note_c3", 3, a_note[3], 20);

      // Asynchronous reset mid-PLAY
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (6) @(posedge clk);
      #3;
      chk("t5_pre_rst_busy", 6, int'(busy), 1);
      chk("t5_pre_rst_note", 6, int'(fullnote), 20);
      rst = 1'b1;
      #1;
      chk("t5_rst_fullnote", 6, int'(fullnote), 0);
      chk("t5_rst_gate", 6, int'(gate), 0);
      chk("t5_rst_busy", 6, int'(busy), 0);
      chk("t5_rst_rom_addr", 6, int'(rom_addr), 0);
      @(posedge clk); #1 rst = 1'b0;

      // 2-bit address space wraps without an END marker
      rom2[0] = ent(0, 1, 1); rom2[1] = ent(0, 2, 2);
      rom2[2] = ent(0, 1, 3); rom2[3] = ent(0, 2, 4);
      run(80, 1'b1, -1);
      chk("t6_addr_c23", 23, a_addr[23], 3);
      chk("t6_addr_c24", 24, a_addr[24], 0);
      chk("t6_step_c27", 27, a_step[27], 1);
      chk("t6_note_c27", 27, a_note[27], 1);
      pulse_stop(1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
